// File: rtl/bus_ram.sv
// bus_ram: 256x8 single-port RAM behind a request/ready memory bus.
// A request is latched in IDLE, held for WAIT_CYCLES wait states, then
// completed in DONE (write committed, or read data driven on the bus).
// A side-band load port can write the array at any time and wins over a
// same-cycle, same-address bus write.
module bus_ram #(
   parameter int    WAIT_CYCLES = 2,
   parameter int    DEPTH       = 256,
   parameter string INIT_FILE   = ""
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mem_req,
   input  logic       we,
   input  logic [7:0] addr,
   inout  wire  [7:0] data,
   output logic       mem_ready,
   input  logic       load_we,
   input  logic [7:0] load_addr,
   input  logic [7:0] load_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Last WAIT count; a zero-wait part still spends one WAIT cycle after a
   // requester switch so that mem_ready visibly drops.
   localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     next_state_s;
   logic [3:0] cnt_r;
   logic [7:0] addr_r;
   logic       we_r;
   logic [7:0] wdata_r;
   logic [7:0] rdata_r;
   logic       ready_r;

   logic       accept_s;
   logic       enter_done_s;
   logic       same_s;
   logic       commit_s;
   logic       drive_s;
   logic [7:0] xfer_addr_s;
   logic       xfer_we_s;
   logic [7:0] xfer_wdata_s;

   logic [7:0] mem_r [0:DEPTH-1];

   // Next-state logic plus the accept / completion strobes.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      enter_done_s = 1'b0;
      same_s       = (addr == addr_r) && (we == we_r) && (!we || (data == wdata_r));
      case (state_r)
         ST_IDLE: begin
            if (mem_req) begin
               accept_s = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  next_state_s = ST_DONE;
                  enter_done_s = 1'b1;
               end else begin
                  next_state_s = ST_WAIT;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!mem_req) begin
               next_state_s = ST_IDLE;
            end else if (cnt_r == LAST_CNT) begin
               next_state_s = ST_DONE;
               enter_done_s = 1'b1;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (!mem_req) begin
               next_state_s = ST_IDLE;
            end else if (same_s) begin
               next_state_s = ST_DONE;
            end else begin
               // Different requester: re-accept and always pass through WAIT.
               accept_s     = 1'b1;
               next_state_s = ST_WAIT;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Select the transfer fields: latched ones from WAIT, live bus on a zero-wait accept.
   always_comb begin
      xfer_addr_s  = addr;
      xfer_we_s    = we;
      xfer_wdata_s = data;
      if (state_r == ST_WAIT) begin
         xfer_addr_s  = addr_r;
         xfer_we_s    = we_r;
         xfer_wdata_s = wdata_r;
      end else begin
         xfer_addr_s  = addr;
         xfer_we_s    = we;
         xfer_wdata_s = data;
      end
      commit_s = enter_done_s && xfer_we_s;
   end

   // Controller registers: state, wait counter, latched request, read data, ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= 8'h00;
         we_r    <= 1'b0;
         wdata_r <= 8'h00;
         rdata_r <= 8'h00;
         ready_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         ready_r <= (next_state_s == ST_DONE);
         if (accept_s) begin
            addr_r  <= addr;
            we_r    <= we;
            wdata_r <= we ? data : 8'h00;
         end
         if ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= 4'd0;
         end
         // Read data is captured once, on entry to DONE (pre-load-port value).
         if (enter_done_s && !xfer_we_s) begin
            rdata_r <= mem_r[xfer_addr_s[AW-1:0]];
         end
      end
   end

   // Array writes: bus commit on DONE entry, load port overrides a same-address commit.
   always_ff @(posedge clk) begin
      if (commit_s && !(load_we && (load_addr[AW-1:0] == xfer_addr_s[AW-1:0]))) begin
         mem_r[xfer_addr_s[AW-1:0]] <= xfer_wdata_s;
      end
      if (load_we) begin
         mem_r[load_addr[AW-1:0]] <= load_data;
      end
   end

   // Never drive the shared bus while any write is being presented.
   assign drive_s   = (state_r == ST_DONE) && !we_r && !we;
   assign data      = drive_s ? rdata_r : 8'hzz;
   assign mem_ready = ready_r;

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: table-driven per-cycle vectors against a WAIT_CYCLES=2 RAM,
// plus hand-written reset and zero-wait sequences against a second instance.
module tb_bus_ram;

   logic       clk;
   logic       rst_n;

   logic       req, we, lwe;
   logic [7:0] addr, wd, laddr, ldata;
   wire  [7:0] data;
   logic       ready;

   logic       req0, we0, lwe0;
   logic [7:0] addr0, wd0, laddr0, ldata0;
   wire  [7:0] data0;
   logic       ready0;

   int n_vec = 0;
   int n_bad = 0;

   assign data  = we  ? wd  : 8'hzz;
   assign data0 = we0 ? wd0 : 8'hzz;

   bus_ram #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(req), .we(we), .addr(addr),
      .data(data), .mem_ready(ready), .load_we(lwe), .load_addr(laddr),
      .load_data(ldata)
   );

   bus_ram #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_req(req0), .we(we0), .addr(addr0),
      .data(data0), .mem_ready(ready0), .load_we(lwe0), .load_addr(laddr0),
      .load_data(ldata0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       req;
      logic       we;
      logic [7:0] a;
      logic [7:0] d;
      logic       lwe;
      logic [7:0] la;
      logic [7:0] ld;
      logic       e_rdy;
      logic       e_drv;
      logic [7:0] e_dat;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic rq, input logic w, input logic [7:0] a, input logic [7:0] d,
                    input logic lw, input logic [7:0] la, input logic [7:0] ld,
                    input logic er, input logic ed, input logic [7:0] edat);
      vec_t r;
      r.req = rq; r.we = w; r.a = a; r.d = d;
      r.lwe = lw; r.la = la; r.ld = ld;
      r.e_rdy = er; r.e_drv = ed; r.e_dat = edat;
      vecs.push_back(r);
   endtask

   task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got 0x%02h, want 0x%02h", nm, id, act, exp);
      end
   endtask

   // Read through the W=2 instance, checking latency (3 edges with req) and data.
   task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input int id);
      int lat;
      lat = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            lat = i + 1;
            break;
         end
      end
      chk("rd_latency", id, 8'(lat), 8'd3);
      chk("rd_data", id, data, exp);
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req = 1'b0; we = 1'b0; addr = 8'h00; wd = 8'h00;
      lwe = 1'b0; laddr = 8'h00; ldata = 8'h00;
      req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wd0 = 8'h00;
      lwe0 = 1'b0; laddr0 = 8'h00; ldata0 = 8'h00;

      // Load 0x10<-A5, read it: ready on the 3rd edge, bus released after drop.
      v(1'b0,1'b0,8'h00,8'h00, 1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'hA5);
      v(1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'hA5);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      // Write 0x20<-3C, hold 4 cycles, then read back.
      v(1'b1,1'b1,8'h20,8'h3C, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h20,8'h3C, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h20,8'h3C, 1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00);
      for (int k = 0; k < 4; k++) v(1'b1,1'b1,8'h20,8'h3C, 1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'h3C);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      // Write 0x21<-3D, overwrite via load during the hold: a re-commit would show 3D.
      v(1'b1,1'b1,8'h21,8'h3D, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h21,8'h3D, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h21,8'h3D, 1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00);
      v(1'b1,1'b1,8'h21,8'h3D, 1'b1,8'h21,8'h66, 1'b1,1'b0,8'h00);
      v(1'b1,1'b1,8'h21,8'h3D, 1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h21,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h21,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h21,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'h66);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      // Read 0x01 completes, requester switches to write 0x02<-77 with req held.
      v(1'b0,1'b0,8'h00,8'h00, 1'b1,8'h01,8'h5E, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h01,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h01,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h01,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'h5E);
      v(1'b1,1'b1,8'h02,8'h77, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h02,8'h77, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h02,8'h77, 1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h02,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h02,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h02,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'h77);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      // Write 0x30 aborted after one WAIT cycle; old value C3 must survive.
      v(1'b0,1'b0,8'h00,8'h00, 1'b1,8'h30,8'hC3, 1'b0,1'b0,8'h00);
      v(1'b1,1'b1,8'h30,8'h99, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h30,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h30,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);
      v(1'b1,1'b0,8'h30,8'h00, 1'b0,8'h00,8'h00, 1'b1,1'b1,8'hC3);
      v(1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00);

      // Reset state.
      #12;
      chk("rst_ready", 0, {7'h00, ready}, 8'h00);
      chk("rst_drive", 0, {7'h00, dut.drive_s}, 8'h00);
      chk("rst_ready0", 0, {7'h00, ready0}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: apply at negedge, check bus contention, check outputs after the edge.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req = vecs[i].req; we = vecs[i].we; addr = vecs[i].a; wd = vecs[i].d;
         lwe = vecs[i].lwe; laddr = vecs[i].la; ldata = vecs[i].ld;
         #1;
         if (vecs[i].we) chk("no_drive_on_we", i, {7'h00, dut.drive_s}, 8'h00);
         @(posedge clk);
         #1;
         chk("ready", i, {7'h00, ready}, {7'h00, vecs[i].e_rdy});
         chk("drive", i, {7'h00, dut.drive_s}, {7'h00, vecs[i].e_drv});
         if (vecs[i].e_drv) chk("rdata", i, data, vecs[i].e_dat);
      end
      @(negedge clk);
      lwe = 1'b0; req = 1'b0; we = 1'b0;

      // Async reset in WAIT.
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 8'h10;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_ready", 100, {7'h00, ready}, 8'h00);
      chk("rst_wait_drive", 100, {7'h00, dut.drive_s}, 8'h00);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset in DONE: ready and bus drop without a clock edge.
      do_read(8'h20, 8'h3C, 101);
      req = 1'b1; addr = 8'h20;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_ready", 102, {7'h00, ready}, 8'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_done_ready", 102, {7'h00, ready}, 8'h00);
      chk("rst_done_drive", 102, {7'h00, dut.drive_s}, 8'h00);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Array contents survive reset.
      do_read(8'h10, 8'hA5, 103);
      do_read(8'h20, 8'h3C, 104);
      do_read(8'h02, 8'h77, 105);

      // Zero-wait instance: bus write 11 and load 22 to 0x40 in the same cycle.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wd0 = 8'h11;
      lwe0 = 1'b1; laddr0 = 8'h40; ldata0 = 8'h22;
      @(posedge clk);
      #1;
      chk("w0_ready", 200, {7'h00, ready0}, 8'h01);
      @(negedge clk);
      req0 = 1'b0; we0 = 1'b0; lwe0 = 1'b0;
      @(posedge clk);
      #1;
      chk("w0_release", 201, {7'h00, ready0}, 8'h00);
      @(negedge clk);
      req0 = 1'b1; addr0 = 8'h40;
      @(posedge clk);
      #1;
      chk("w0_rd_ready", 202, {7'h00, ready0}, 8'h01);
      chk("w0_rd_data", 202, data0, 8'h22);
      @(negedge clk);
      req0 = 1'b0;
      @(posedge clk);
      // Read completing while the load port writes the same address: old value.
      @(negedge clk);
      req0 = 1'b1; addr0 = 8'h40; lwe0 = 1'b1; laddr0 = 8'h40; ldata0 = 8'h33;
      @(posedge clk);
      #1;
      chk("w0_rd_old", 203, data0, 8'h22);
      @(negedge clk);
      req0 = 1'b0; lwe0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req0 = 1'b1;
      @(posedge clk);
      #1;
      chk("w0_rd_new", 204, data0, 8'h33);
      @(negedge clk);
      req0 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
